// File: rtl/seq_player.sv
// Buffered result-word store with a wrap-around browser for the 7-seg path.
// Optional timed auto-play is enabled by defining AUTO_PLAY_EN.
module seq_player #(
   parameter int DEPTH  = 10,
   parameter int WIDTH  = 32,
   parameter int AW     = 4,
   parameter int PERIOD = 50000000
) (
   input  logic             clk,
   input  logic             btn_rst_out_enable,
   input  logic             wr_stb,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr,
   input  logic             nxt,
   input  logic             prv,
   input  logic             auto_tgl,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW-1:0]    rd_idx,
   output logic [AW-1:0]    count,
   output logic             rd_valid,
   output logic             full,
   output logic             overflow,
   output logic             auto_on
);

   localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
   localparam logic [AW-1:0] ONE     = AW'(1);

`ifdef AUTO_PLAY_EN
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] TERM = TW'(PERIOD - 1);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_BROWSE,
      ST_AUTO
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_BROWSE
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [AW-1:0]    count_q, count_d;
   logic [AW-1:0]    rd_idx_q, rd_idx_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic wr_ok;
   logic fwd;
   logic bwd;
   logic step_f;
   logic step_b;

`ifdef AUTO_PLAY_EN
   logic [TW-1:0] timer_q, timer_d;
`else
   logic unused_auto;
   assign unused_auto = auto_tgl | (PERIOD < 2);
`endif

   assign wr_ok = wr_stb && (count_q != DEPTH_C);
   assign fwd   = nxt && !prv;
   assign bwd   = prv && !nxt;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      step_f     = 1'b0;
      step_b     = 1'b0;
`ifdef AUTO_PLAY_EN
      timer_d    = timer_q;
`endif

      if (clr) begin
         state_d    = ST_EMPTY;
         count_d    = '0;
         rd_idx_d   = '0;
         rd_data_d  = '0;
         overflow_d = 1'b0;
`ifdef AUTO_PLAY_EN
         timer_d    = '0;
`endif
      end else begin
         if (wr_stb && !wr_ok) begin
            overflow_d = 1'b1;
         end
         if (wr_ok) begin
            mem_d[count_q] = wr_data;
            count_d        = count_q + ONE;
         end

         unique case (state_q)
            ST_EMPTY: begin
               if (wr_ok) begin
                  state_d  = ST_BROWSE;
                  rd_idx_d = '0;
               end
            end
            ST_BROWSE: begin
               step_f = fwd;
               step_b = bwd;
`ifdef AUTO_PLAY_EN
               if (auto_tgl) begin
                  state_d = ST_AUTO;
                  timer_d = '0;
               end
`endif
            end
`ifdef AUTO_PLAY_EN
            ST_AUTO: begin
               step_b = bwd;
               // A manual pulse (even a cancelling nxt+prv) restarts the interval.
               if (nxt || prv) begin
                  step_f  = fwd;
                  timer_d = '0;
               end else if (timer_q == TERM) begin
                  step_f  = 1'b1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
               if (auto_tgl) begin
                  state_d = ST_BROWSE;
                  timer_d = '0;
               end
            end
`endif
            default: begin
               state_d = ST_EMPTY;
            end
         endcase

         // Wrap limit deliberately uses the pre-write count.
         unique case (1'b1)
            step_f: begin
               rd_idx_d = (rd_idx_q == count_q - ONE) ? '0 : rd_idx_q + ONE;
            end
            step_b: begin
               rd_idx_d = (rd_idx_q == '0) ? count_q - ONE : rd_idx_q - ONE;
            end
            default: begin
            end
         endcase

         if (count_d == '0) begin
            rd_data_d = '0;
         end else if (wr_ok && (rd_idx_d == count_q)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_idx_d];
         end
      end
   end

   always_ff @(posedge clk or posedge btn_rst_out_enable) begin
      if (btn_rst_out_enable) begin
         state_q    <= ST_EMPTY;
         count_q    <= '0;
         rd_idx_q   <= '0;
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef AUTO_PLAY_EN
         timer_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_idx_q   <= rd_idx_d;
         rd_data_q  <= rd_data_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
`ifdef AUTO_PLAY_EN
         timer_q    <= timer_d;
`endif
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_idx   = rd_idx_q;
   assign count    = count_q;
   assign rd_valid = (count_q != '0);
   assign full     = (count_q == DEPTH_C);
   assign overflow = overflow_q;
`ifdef AUTO_PLAY_EN
   assign auto_on  = (state_q == ST_AUTO);
`else
   assign auto_on  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_seq_player;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_stb;
   logic [31:0] wr_data;
   logic        clr;
   logic        nxt;
   logic        prv;
   logic        auto_tgl;
   logic [31:0] rd_data;
   logic [3:0]  rd_idx;
   logic [3:0]  count;
   logic        rd_valid;
   logic        full;
   logic        overflow;
   logic        auto_on;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic [31:0] d;
      logic [3:0]  idx;
      logic [3:0]  cnt;
      logic        v;
      logic        f;
      logic        o;
      logic        a;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_player #(
      .DEPTH(10),
      .WIDTH(32),
      .AW(4),
      .PERIOD(4)
   ) dut (
      .clk(clk),
      .btn_rst_out_enable(rst),
      .wr_stb(wr_stb),
      .wr_data(wr_data),
      .clr(clr),
      .nxt(nxt),
      .prv(prv),
      .auto_tgl(auto_tgl),
      .rd_data(rd_data),
      .rd_idx(rd_idx),
      .count(count),
      .rd_valid(rd_valid),
      .full(full),
      .overflow(overflow),
      .auto_on(auto_on)
   );

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (rd_data !== e.d || rd_idx !== e.idx || count !== e.cnt ||
             rd_valid !== e.v || full !== e.f || overflow !== e.o ||
             auto_on !== e.a) begin
            errors++;
            $display("FAIL %s: got d=%h i=%0d c=%0d v=%b f=%b o=%b a=%b want d=%h i=%0d c=%0d v=%b f=%b o=%b a=%b",
                     e.nm, rd_data, rd_idx, count, rd_valid, full, overflow,
                     auto_on, e.d, e.idx, e.cnt, e.v, e.f, e.o, e.a);
         end
      end
   end

   task automatic push(input string nm, input logic [31:0] ed,
                       input logic [3:0] ei, input logic [3:0] ec,
                       input logic eo, input logic ea);
      exp_t e;
      e.nm  = nm;
      e.d   = ed;
      e.idx = ei;
      e.cnt = ec;
      e.v   = (ec != 4'd0);
      e.f   = (ec == 4'd10);
      e.o   = eo;
      e.a   = ea;
      sb.push_back(e);
   endtask

   task automatic cyc(input string nm, input logic w, input logic [31:0] wd,
                      input logic c, input logic n, input logic p,
                      input logic t, input logic [31:0] ed,
                      input logic [3:0] ei, input logic [3:0] ec,
                      input logic eo, input logic ea);
      wr_stb   = w;
      wr_data  = wd;
      clr      = c;
      nxt      = n;
      prv      = p;
      auto_tgl = t;
      @(posedge clk);
      #1;
      wr_stb   = 1'b0;
      clr      = 1'b0;
      nxt      = 1'b0;
      prv      = 1'b0;
      auto_tgl = 1'b0;
      push(nm, ed, ei, ec, eo, ea);
      @(negedge clk);
      #1;
   endtask

   logic [31:0] wv [3];

   initial begin
      rst      = 1'b1;
      wr_stb   = 1'b0;
      wr_data  = '0;
      clr      = 1'b0;
      nxt      = 1'b0;
      prv      = 1'b0;
      auto_tgl = 1'b0;
      @(negedge clk);
      #1;
      push("reset", 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;

      cyc("w11", 1, 32'h11, 0, 0, 0, 0, 32'h11, 0, 1, 0, 0);
      cyc("w22", 1, 32'h22, 0, 0, 0, 0, 32'h11, 0, 2, 0, 0);
      cyc("w33", 1, 32'h33, 0, 0, 0, 0, 32'h11, 0, 3, 0, 0);
      cyc("nxt1", 0, 0, 0, 1, 0, 0, 32'h22, 1, 3, 0, 0);
      cyc("nxt2", 0, 0, 0, 1, 0, 0, 32'h33, 2, 3, 0, 0);
      cyc("nxt_wrap", 0, 0, 0, 1, 0, 0, 32'h11, 0, 3, 0, 0);
      cyc("prv_wrap", 0, 0, 0, 0, 1, 0, 32'h33, 2, 3, 0, 0);

      @(posedge clk);
      #2;
      rst = 1'b1;
      push("async_rst", 32'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc("post_rst_nxt", 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         cyc("fill", 1, 32'h100 + i, 0, 0, 0, 0, 32'h100, 0, 4'(i + 1), 0, 0);
      end
      cyc("ovf", 1, 32'hDEAD, 0, 0, 0, 0, 32'h100, 0, 10, 1, 0);
      for (int k = 0; k < 10; k++) begin
         cyc("walk", 0, 0, 0, 1, 0, 0, 32'h100 + ((k + 1) % 10),
             4'((k + 1) % 10), 10, 1, 0);
      end
      cyc("clr", 0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);

      cyc("w41", 1, 32'h41, 0, 0, 0, 0, 32'h41, 0, 1, 0, 0);
      cyc("w42", 1, 32'h42, 0, 0, 0, 0, 32'h41, 0, 2, 0, 0);
      cyc("nxt_to1", 0, 0, 0, 1, 0, 0, 32'h42, 1, 2, 0, 0);
      cyc("nxt_wr44", 1, 32'h44, 0, 1, 0, 0, 32'h41, 0, 3, 0, 0);
      cyc("nxt_prv", 0, 0, 0, 1, 1, 0, 32'h41, 0, 3, 0, 0);
      cyc("prv_44", 0, 0, 0, 0, 1, 0, 32'h44, 2, 3, 0, 0);
      cyc("clr_wr", 1, 32'h55, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);

`ifdef AUTO_PLAY_EN
      wv[0] = 32'h51;
      wv[1] = 32'h52;
      wv[2] = 32'h53;
      cyc("w51", 1, wv[0], 0, 0, 0, 0, wv[0], 0, 1, 0, 0);
      cyc("w52", 1, wv[1], 0, 0, 0, 0, wv[0], 0, 2, 0, 0);
      cyc("w53", 1, wv[2], 0, 0, 0, 0, wv[0], 0, 3, 0, 0);
      cyc("auto_on", 0, 0, 0, 0, 0, 1, wv[0], 0, 3, 0, 1);
      for (int s = 1; s <= 12; s++) begin
         cyc("auto_run", 0, 0, 0, 0, 0, 0, wv[(s / 4) % 3],
             4'((s / 4) % 3), 3, 0, 1);
      end
      cyc("auto_idle1", 0, 0, 0, 0, 0, 0, wv[0], 0, 3, 0, 1);
      cyc("auto_idle2", 0, 0, 0, 0, 0, 0, wv[0], 0, 3, 0, 1);
      cyc("auto_nxt", 0, 0, 0, 1, 0, 0, wv[1], 1, 3, 0, 1);
      for (int s = 1; s <= 3; s++) begin
         cyc("auto_hold", 0, 0, 0, 0, 0, 0, wv[1], 1, 3, 0, 1);
      end
      cyc("auto_restep", 0, 0, 0, 0, 0, 0, wv[2], 2, 3, 0, 1);
      cyc("auto_off", 0, 0, 0, 0, 0, 1, wv[2], 2, 3, 0, 0);
      for (int s = 0; s < 6; s++) begin
         cyc("browse_idle", 0, 0, 0, 0, 0, 0, wv[2], 2, 3, 0, 0);
      end
`else
      wv[0] = 32'h61;
      wv[1] = 32'h62;
      wv[2] = 32'h63;
      cyc("w61", 1, wv[0], 0, 0, 0, 0, wv[0], 0, 1, 0, 0);
      cyc("w62", 1, wv[1], 0, 0, 0, 0, wv[0], 0, 2, 0, 0);
      cyc("w63", 1, wv[2], 0, 0, 0, 0, wv[0], 0, 3, 0, 0);
      cyc("tgl_ign", 0, 0, 0, 0, 0, 1, wv[0], 0, 3, 0, 0);
      for (int s = 0; s < 20; s++) begin
         cyc("no_auto", 0, 0, 0, 0, 0, 0, wv[0], 0, 3, 0, 0);
      end
`endif

      for (int b = 0; b < 10 && sb.size() > 0; b++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
